// File: rtl/fifo_bit_deser_if.sv
// Bus bundle for fifo_bit_deser: FIFO pop side plus downstream word handshake.
// master = deserializer, slave = FIFO/consumer environment.
interface fifo_bit_deser_if #(
  parameter int WIDTH = 8
) ();
  logic             fifo_empty;
  logic             fifo_dout;
  logic             fifo_r_en;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    input  fifo_empty,
    input  fifo_dout,
    input  out_ready,
    output fifo_r_en,
    output out_data,
    output out_valid
  );

  modport slave (
    output fifo_empty,
    output fifo_dout,
    output out_ready,
    input  fifo_r_en,
    input  out_data,
    input  out_valid
  );
endinterface

// File: rtl/fifo_bit_deser.sv
// Read-side consumer of the 1-bit async FIFO: pops serial bits and
// assembles them into WIDTH-bit words on a valid/ready output.
module fifo_bit_deser #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic busy,
  fifo_bit_deser_if.master bus
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             inflight_q;
  logic             valid_q, valid_d;
  logic             r_en;
  logic             xfer;
  logic [CW:0]      fill;

  // Bits stored plus the one still in the FIFO's read register.
  assign fill = {1'b0, cnt_q} + {{CW{1'b0}}, inflight_q};

  assign r_en = rst_n & en & ~bus.fifo_empty
              & (fill < (CW+1)'(WIDTH));

  assign xfer = (cnt_q == CW'(WIDTH))
              & (~valid_q | bus.out_ready);

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    if (inflight_q) begin
      if (MSB_FIRST)
        shreg_d = {shreg_q[WIDTH-2:0], bus.fifo_dout};
      else
        shreg_d = {bus.fifo_dout, shreg_q[WIDTH-1:1]};
      cnt_d = cnt_q + CW'(1);
    end
    if (xfer) begin
      data_d  = shreg_q;
      valid_d = 1'b1;
      cnt_d   = '0;
    end else if (valid_q && bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg_q    <= '0;
      data_q     <= '0;
      cnt_q      <= '0;
      inflight_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      shreg_q    <= shreg_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      inflight_q <= r_en;
      valid_q    <= valid_d;
    end
  end

  assign bus.fifo_r_en = r_en;
  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign busy = (cnt_q != '0) | inflight_q | valid_q;

endmodule

// File: tb/tb_fifo_bit_deser.sv
// Self-checking bench for fifo_bit_deser: FIFO model feeds bits,
// words are checked against the values the bits were serialised from.
module tb_fifo_bit_deser;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic en;
  logic busy_m, busy_l;

  fifo_bit_deser_if #(.WIDTH(W)) bm ();
  fifo_bit_deser_if #(.WIDTH(W)) bl ();

  fifo_bit_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) u_m (
    .clk(clk), .rst_n(rst_n), .en(en),
    .busy(busy_m), .bus(bm)
  );

  fifo_bit_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) u_l (
    .clk(clk), .rst_n(rst_n), .en(en),
    .busy(busy_l), .bus(bl)
  );

  int vectors = 0;
  int miscompares = 0;

  bit bits_m [0:2047];
  bit bits_l [0:2047];
  int wp_m = 0, rp_m = 0;
  int wp_l = 0, rp_l = 0;
  logic [W-1:0] got_m [$];
  logic [W-1:0] got_l [$];

  assign bm.fifo_empty = (rp_m == wp_m);
  assign bl.fifo_empty = (rp_l == wp_l);

  // FIFO read port: registered data one cycle after the pop.
  always @(posedge clk) begin
    if (bm.fifo_r_en) begin
      bm.fifo_dout <= bits_m[rp_m];
      rp_m <= rp_m + 1;
    end
    if (bm.out_valid && bm.out_ready)
      got_m.push_back(bm.out_data);
  end

  always @(posedge clk) begin
    if (bl.fifo_r_en) begin
      bl.fifo_dout <= bits_l[rp_l];
      rp_l <= rp_l + 1;
    end
    if (bl.out_valid && bl.out_ready)
      got_l.push_back(bl.out_data);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_bits_m(input logic [W-1:0] w,
                             input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      bits_m[wp_m] = w[i];
      wp_m++;
    end
  endtask

  task automatic push_m(input logic [W-1:0] w);
    push_bits_m(w, W-1, 0);
  endtask

  // pat[W-1] is the first bit into the FIFO.
  task automatic push_l(input logic [W-1:0] pat);
    for (int i = W-1; i >= 0; i--) begin
      bits_l[wp_l] = pat[i];
      wp_l++;
    end
  endtask

  task automatic test_reset();
    logic [W-1:0] r;
    r = W'($urandom());
    rst_n = 1'b0;
    en = 1'b1;
    bm.out_ready = 1'b1;
    bl.out_ready = 1'b1;
    push_m(r);
    tick();
    tick();
    vectors++;
    if (bm.fifo_r_en !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_ren got=%b exp=0", bm.fifo_r_en);
    end
    vectors++;
    if (bm.out_valid !== 1'b0 || bl.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_valid got=%b/%b exp=0/0",
               bm.out_valid, bl.out_valid);
    end
    vectors++;
    if (bm.out_data !== '0) begin
      miscompares++;
      $display("FAIL rst_data got=%h exp=00", bm.out_data);
    end
    vectors++;
    if (busy_m !== 1'b0 || busy_l !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_busy got=%b/%b exp=0/0", busy_m, busy_l);
    end
    vectors++;
    if (rp_m !== 0) begin
      miscompares++;
      $display("FAIL rst_pops got=%0d exp=0", rp_m);
    end
    rst_n = 1'b1;
    #1;
    vectors++;
    if (bm.fifo_r_en !== 1'b1) begin
      miscompares++;
      $display("FAIL rel_ren got=%b exp=1", bm.fifo_r_en);
    end
    for (int i = 0; i < 40; i++) begin
      tick();
      if (got_m.size() >= 1) break;
    end
    vectors++;
    if (got_m.size() != 1) begin
      miscompares++;
      $display("FAIL rst_word_cnt got=%0d exp=1", got_m.size());
    end else begin
      vectors++;
      if (got_m[0] !== r) begin
        miscompares++;
        $display("FAIL rst_word got=%h exp=%h", got_m[0], r);
      end
    end
  endtask

  task automatic test_first_word();
    logic exp_r, exp_v;
    logic [W-1:0] exp_d;
    en = 1'b0;
    bm.out_ready = 1'b1;
    push_m(8'hA5);
    push_m(8'h5A);
    tick();
    en = 1'b1;
    #1;
    vectors++;
    if (bm.fifo_r_en !== 1'b1 || bm.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL first_c0 got=%b/%b exp=1/0",
               bm.fifo_r_en, bm.out_valid);
    end
    for (int c = 1; c <= 21; c++) begin
      tick();
      exp_r = (c <= 7) || (c >= 10 && c <= 17);
      exp_v = (c == 10) || (c == 20);
      exp_d = (c == 10) ? 8'hA5 : 8'h5A;
      vectors++;
      if (bm.fifo_r_en !== exp_r) begin
        miscompares++;
        $display("FAIL first_ren c=%0d got=%b exp=%b",
                 c, bm.fifo_r_en, exp_r);
      end
      vectors++;
      if (bm.out_valid !== exp_v) begin
        miscompares++;
        $display("FAIL first_valid c=%0d got=%b exp=%b",
                 c, bm.out_valid, exp_v);
      end
      if (exp_v) begin
        vectors++;
        if (bm.out_data !== exp_d) begin
          miscompares++;
          $display("FAIL first_data c=%0d got=%h exp=%h",
                   c, bm.out_data, exp_d);
        end
      end
    end
  endtask

  task automatic test_lsb_first();
    int base;
    base = got_l.size();
    en = 1'b1;
    bl.out_ready = 1'b1;
    push_l(8'b10100101);
    push_l(8'b11000000);
    for (int i = 0; i < 60; i++) begin
      tick();
      if (got_l.size() >= base + 2) break;
    end
    vectors++;
    if (got_l.size() != base + 2) begin
      miscompares++;
      $display("FAIL lsb_cnt got=%0d exp=%0d",
               got_l.size(), base + 2);
    end else begin
      vectors++;
      if (got_l[base] !== 8'hA5) begin
        miscompares++;
        $display("FAIL lsb_w0 got=%h exp=a5", got_l[base]);
      end
      vectors++;
      if (got_l[base+1] !== 8'h03) begin
        miscompares++;
        $display("FAIL lsb_w1 got=%h exp=03", got_l[base+1]);
      end
    end
  endtask

  task automatic test_backpressure();
    int base;
    int rp0;
    base = got_m.size();
    en = 1'b1;
    bm.out_ready = 1'b0;
    push_m(8'h3C);
    push_m(8'hC3);
    for (int i = 0; i < 40; i++) tick();
    vectors++;
    if (bm.out_valid !== 1'b1 || bm.out_data !== 8'h3C) begin
      miscompares++;
      $display("FAIL bp_hold got=%b/%h exp=1/3c",
               bm.out_valid, bm.out_data);
    end
    vectors++;
    if (bm.fifo_r_en !== 1'b0 || busy_m !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_ren_busy got=%b/%b exp=0/1",
               bm.fifo_r_en, busy_m);
    end
    vectors++;
    if (rp_m !== wp_m) begin
      miscompares++;
      $display("FAIL bp_pops got=%0d exp=%0d", rp_m, wp_m);
    end
    push_m(8'h99);
    rp0 = rp_m;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (bm.fifo_r_en !== 1'b0 || bm.out_data !== 8'h3C) begin
        miscompares++;
        $display("FAIL bp_stall got=%b/%h exp=0/3c",
                 bm.fifo_r_en, bm.out_data);
      end
    end
    vectors++;
    if (rp_m !== rp0) begin
      miscompares++;
      $display("FAIL bp_accum got=%0d exp=%0d", rp_m, rp0);
    end
    bm.out_ready = 1'b1;
    tick();
    vectors++;
    if (bm.out_valid !== 1'b1 || bm.out_data !== 8'hC3) begin
      miscompares++;
      $display("FAIL bp_swap got=%b/%h exp=1/c3",
               bm.out_valid, bm.out_data);
    end
    tick();
    bm.out_ready = 1'b0;
    vectors++;
    if (bm.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_drain got=%b exp=0", bm.out_valid);
    end
    bm.out_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (got_m.size() >= base + 3) break;
    end
    vectors++;
    if (got_m.size() != base + 3) begin
      miscompares++;
      $display("FAIL bp_cnt got=%0d exp=%0d",
               got_m.size(), base + 3);
    end else begin
      vectors++;
      if (got_m[base] !== 8'h3C || got_m[base+1] !== 8'hC3
          || got_m[base+2] !== 8'h99) begin
        miscompares++;
        $display("FAIL bp_seq got=%h,%h,%h exp=3c,c3,99",
                 got_m[base], got_m[base+1], got_m[base+2]);
      end
    end
  endtask

  task automatic test_empty_pause();
    logic [W-1:0] w;
    int base;
    w = W'($urandom());
    base = got_m.size();
    en = 1'b1;
    bm.out_ready = 1'b1;
    push_bits_m(w, W-1, W-3);
    for (int i = 0; i < 5; i++) tick();
    for (int i = 0; i < 20; i++) begin
      tick();
      vectors++;
      if (bm.fifo_r_en !== 1'b0 || busy_m !== 1'b1
          || bm.out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL pause i=%0d ren/busy/v got=%b%b%b exp=010",
                 i, bm.fifo_r_en, busy_m, bm.out_valid);
      end
    end
    push_bits_m(w, W-4, 0);
    for (int i = 0; i < 30; i++) begin
      tick();
      if (got_m.size() > base) break;
      vectors++;
      if (busy_m !== 1'b1) begin
        miscompares++;
        $display("FAIL refill_busy i=%0d got=%b exp=1", i, busy_m);
      end
    end
    vectors++;
    if (got_m.size() != base + 1) begin
      miscompares++;
      $display("FAIL refill_cnt got=%0d exp=%0d",
               got_m.size(), base + 1);
    end else begin
      vectors++;
      if (got_m[base] !== w) begin
        miscompares++;
        $display("FAIL refill_word got=%h exp=%h", got_m[base], w);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] junk;
    int base;
    junk = W'($urandom());
    base = got_m.size();
    en = 1'b0;
    bm.out_ready = 1'b1;
    push_bits_m(junk, W-1, 2);
    tick();
    en = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    vectors++;
    if (busy_m !== 1'b1 || rp_m !== wp_m) begin
      miscompares++;
      $display("FAIL mid_pre busy=%b rp=%0d got, exp busy=1 rp=%0d",
               busy_m, rp_m, wp_m);
    end
    rst_n = 1'b0;
    en = 1'b0;
    #1;
    vectors++;
    if (bm.fifo_r_en !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_ren got=%b exp=0", bm.fifo_r_en);
    end
    tick();
    vectors++;
    if (bm.out_valid !== 1'b0 || busy_m !== 1'b0
        || bm.fifo_r_en !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_rst v/busy/ren got=%b%b%b exp=000",
               bm.out_valid, busy_m, bm.fifo_r_en);
    end
    rst_n = 1'b1;
    push_m(8'h81);
    en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (got_m.size() > base) break;
    end
    for (int i = 0; i < 5; i++) tick();
    vectors++;
    if (got_m.size() != base + 1) begin
      miscompares++;
      $display("FAIL mid_cnt got=%0d exp=%0d",
               got_m.size(), base + 1);
    end else begin
      vectors++;
      if (got_m[base] !== 8'h81) begin
        miscompares++;
        $display("FAIL mid_word got=%h exp=81", got_m[base]);
      end
    end
    vectors++;
    if (busy_m !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_idle got=%b exp=0", busy_m);
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 24;
    logic [W-1:0] exp_q [$];
    logic [W-1:0] w;
    logic [W-1:0] prev_data;
    logic prev_hold;
    int base;
    base = got_m.size();
    prev_hold = 1'b0;
    prev_data = '0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      tick();
      if (prev_hold) begin
        vectors++;
        if (bm.out_valid !== 1'b1 || bm.out_data !== prev_data) begin
          miscompares++;
          $display("FAIL b2b_stable got=%b/%h exp=1/%h",
                   bm.out_valid, bm.out_data, prev_data);
        end
      end
      if (got_m.size() >= base + N) break;
      if (exp_q.size() < N && $urandom_range(2) == 0) begin
        w = W'($urandom());
        exp_q.push_back(w);
        push_m(w);
      end
      if (cyc < 3000) begin
        en = ($urandom_range(3) != 0);
        bm.out_ready = 1'($urandom_range(1));
      end else begin
        en = 1'b1;
        bm.out_ready = 1'b1;
      end
      #1;
      prev_hold = bm.out_valid && !bm.out_ready;
      prev_data = bm.out_data;
    end
    vectors++;
    if (got_m.size() != base + N) begin
      miscompares++;
      $display("FAIL b2b_cnt got=%0d exp=%0d",
               got_m.size(), base + N);
    end else begin
      for (int i = 0; i < N; i++) begin
        vectors++;
        if (got_m[base+i] !== exp_q[i]) begin
          miscompares++;
          $display("FAIL b2b_word i=%0d got=%h exp=%h",
                   i, got_m[base+i], exp_q[i]);
        end
      end
    end
    bm.out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_first_word();
    test_lsb_first();
    test_backpressure();
    test_empty_pause();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
